// File: rtl/periph_bus.sv
// periph_bus: memory-mapped I/O register block on the I/O side of the bus.
//
// Purpose:
//   Decodes CPU I/O requests into a small register file that controls
//   output-only pins, samples input-only pins, manages bidirectional GPIO
//   and per-pin edge interrupts, and runs byte-wide SPI transfers through
//   a handshake with a shared SPI engine. The engine is guarded by a watchdog.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start_request     request strobe, held until request_done is seen
//   is_write          1 = write, 0 = read
//   target_address    register byte offset
//   write_value       write data
//   fetched_value     registered read data, zero-extended
//   request_done      request complete; held until start_request drops
//   outputs           output-only pins
//   inputs            input-only pins (asynchronous, synchronised here)
//   io_direction      GPIO direction, 1 = output
//   io_outputs        GPIO output values (PIN_OUT masked by direction)
//   io_inputs         GPIO pad values (asynchronous, synchronised here)
//   spi_start         level request to the SPI engine
//   spi_tx_byte       byte to send
//   spi_done          engine completion
//   spi_rx_byte       received byte, valid with spi_done
//   spi_cs_n          active-low chip selects
//   irq               registered OR of (pending & enable)
module periph_bus #(
    parameter int OUT_PINS    = 4,
    parameter int IN_PINS     = 5,
    parameter int IO_PINS     = 7,
    parameter int NUM_CS      = 4,
    parameter int SPI_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_request,
    input  logic                is_write,
    input  logic [7:0]          target_address,
    input  logic [31:0]         write_value,
    output logic [31:0]         fetched_value,
    output logic                request_done,
    output logic [OUT_PINS-1:0] outputs,
    input  logic [IN_PINS-1:0]  inputs,
    output logic [IO_PINS-1:0]  io_direction,
    output logic [IO_PINS-1:0]  io_outputs,
    input  logic [IO_PINS-1:0]  io_inputs,
    output logic                spi_start,
    output logic [7:0]          spi_tx_byte,
    input  logic                spi_done,
    input  logic [7:0]          spi_rx_byte,
    output logic [NUM_CS-1:0]   spi_cs_n,
    output logic                irq
);

    localparam logic [7:0] ADDR_OUT      = 8'h00;
    localparam logic [7:0] ADDR_IN       = 8'h01;
    localparam logic [7:0] ADDR_DIR      = 8'h02;
    localparam logic [7:0] ADDR_PIN_IN   = 8'h03;
    localparam logic [7:0] ADDR_PIN_OUT  = 8'h04;
    localparam logic [7:0] ADDR_SPI_CTRL = 8'h05;
    localparam logic [7:0] ADDR_SPI_TX   = 8'h08;
    localparam logic [7:0] ADDR_SPI_RX   = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h18;
    localparam logic [7:0] ADDR_IRQ_EDGE = 8'h19;
    localparam logic [7:0] ADDR_IRQ_PEND = 8'h1A;

    localparam int CNT_W = $clog2(SPI_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [OUT_PINS-1:0] r_out;
    logic [IO_PINS-1:0]  r_dir;
    logic [IO_PINS-1:0]  r_pin_out;
    logic [7:0]          r_tx;
    logic [7:0]          r_rx;
    logic [IO_PINS-1:0]  r_irq_en;
    logic [IO_PINS-1:0]  r_irq_edge;
    logic [IO_PINS-1:0]  r_irq_pend;
    logic                r_irq;
    logic [NUM_CS-1:0]   r_cs;
    logic                r_spi_done;
    logic                r_spi_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_fetched;
    logic [IN_PINS-1:0]  r_in_s1, r_in_s2;
    logic [IO_PINS-1:0]  r_io_s1, r_io_s2, r_io_prev;

    logic                w_accept, w_wr, w_rd, w_spi_go, w_busy;
    logic                w_spi_ok, w_timeout;
    logic [NUM_CS-1:0]   w_cs_sel;
    logic                w_cs_onehot;
    logic [31:0]         w_rdata;
    logic [IO_PINS-1:0]  w_edge, w_w1c, w_pend_next;

    // Requests are only taken in IDLE; the access itself happens on that edge.
    assign w_accept    = (r_state == S_IDLE) && start_request;
    assign w_wr        = w_accept && is_write;
    assign w_rd        = w_accept && !is_write;
    assign w_spi_go    = w_wr && (target_address == ADDR_SPI_CTRL) && write_value[0];
    assign w_busy      = (r_state == S_PEND);
    assign w_cs_sel    = write_value[NUM_CS:1];
    assign w_cs_onehot = (w_cs_sel != '0) && ((w_cs_sel & (w_cs_sel - 1'b1)) == '0);

    // Abort (start_request dropped) beats completion; completion beats timeout.
    assign w_spi_ok  = w_busy && start_request && spi_done;
    assign w_timeout = w_busy && start_request && !spi_done &&
                       (r_cnt == CNT_W'(SPI_TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start_request) w_state_next = w_spi_go ? S_PEND : S_DONE;
            S_PEND: begin
                if (!start_request)           w_state_next = S_IDLE;
                else if (w_spi_ok || w_timeout) w_state_next = S_DONE;
            end
            S_DONE: if (!start_request) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (target_address)
            ADDR_OUT:      w_rdata[OUT_PINS-1:0] = r_out;
            ADDR_IN:       w_rdata[IN_PINS-1:0]  = r_in_s2;
            ADDR_DIR:      w_rdata[IO_PINS-1:0]  = r_dir;
            ADDR_PIN_IN:   w_rdata[IO_PINS-1:0]  = r_io_s2 & ~r_dir;
            ADDR_PIN_OUT:  w_rdata[IO_PINS-1:0]  = r_pin_out;
            ADDR_SPI_CTRL: w_rdata[2:0]          = {r_spi_err, r_spi_done, w_busy};
            ADDR_SPI_TX:   w_rdata[7:0]          = r_tx;
            ADDR_SPI_RX:   w_rdata[7:0]          = r_rx;
            ADDR_IRQ_EN:   w_rdata[IO_PINS-1:0]  = r_irq_en;
            ADDR_IRQ_EDGE: w_rdata[IO_PINS-1:0]  = r_irq_edge;
            ADDR_IRQ_PEND: w_rdata[IO_PINS-1:0]  = r_irq_pend;
            default:       w_rdata               = '0;
        endcase
    end

    // Per-pin edge detect on synchronised pads; pins driven as outputs never flag.
    genvar gi;
    generate
        for (gi = 0; gi < IO_PINS; gi++) begin : g_edge
            assign w_edge[gi] = ~r_dir[gi] &
                                (r_irq_edge[gi] ? (r_io_prev[gi] & ~r_io_s2[gi])
                                                : (~r_io_prev[gi] & r_io_s2[gi]));
        end
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign spi_cs_n[gi] = ~(w_busy & r_cs[gi]);
        end
    endgenerate

    assign w_w1c       = (w_wr && (target_address == ADDR_IRQ_PEND)) ?
                         write_value[IO_PINS-1:0] : '0;
    // A new edge in the clearing cycle keeps the bit set.
    assign w_pend_next = (r_irq_pend & ~w_w1c) | w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_out      <= '0;
            r_dir      <= '0;
            r_pin_out  <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_irq_en   <= '0;
            r_irq_edge <= '0;
            r_irq_pend <= '0;
            r_irq      <= 1'b0;
            r_cs       <= '0;
            r_spi_done <= 1'b0;
            r_spi_err  <= 1'b0;
            r_cnt      <= '0;
            r_fetched  <= '0;
            r_in_s1    <= '0;
            r_in_s2    <= '0;
            r_io_s1    <= '0;
            r_io_s2    <= '0;
            r_io_prev  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_s1    <= inputs;
            r_in_s2    <= r_in_s1;
            r_io_s1    <= io_inputs;
            r_io_s2    <= r_io_s1;
            r_io_prev  <= r_io_s2;
            r_irq_pend <= w_pend_next;
            r_irq      <= |(r_irq_pend & r_irq_en);

            if (w_rd) r_fetched <= w_rdata;

            if (w_wr) begin
                case (target_address)
                    ADDR_OUT:      r_out      <= write_value[OUT_PINS-1:0];
                    ADDR_DIR:      r_dir      <= write_value[IO_PINS-1:0];
                    ADDR_PIN_OUT:  r_pin_out  <= write_value[IO_PINS-1:0];
                    ADDR_SPI_TX:   r_tx       <= write_value[7:0];
                    ADDR_IRQ_EN:   r_irq_en   <= write_value[IO_PINS-1:0];
                    ADDR_IRQ_EDGE: r_irq_edge <= write_value[IO_PINS-1:0];
                    default:       ;
                endcase
            end

            if (w_spi_go) begin
                // Multi-hot or empty selects still transfer, with no CS asserted.
                r_cs       <= w_cs_onehot ? w_cs_sel : '0;
                r_spi_done <= 1'b0;
                r_spi_err  <= 1'b0;
                r_cnt      <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_spi_ok) begin
                r_rx       <= spi_rx_byte;
                r_spi_done <= 1'b1;
            end
            if (w_timeout) r_spi_err <= 1'b1;
        end
    end

    assign fetched_value = r_fetched;
    assign request_done  = (r_state == S_DONE);
    assign outputs       = r_out;
    assign io_direction  = r_dir;
    assign io_outputs    = r_pin_out & r_dir;
    assign spi_start     = w_busy;
    assign spi_tx_byte   = r_tx;
    assign irq           = r_irq;

endmodule

// File: tb/tb_periph_bus.sv
module tb_periph_bus;
    localparam int OUT_PINS = 4;
    localparam int IN_PINS  = 5;
    localparam int IO_PINS  = 7;
    localparam int NUM_CS   = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start_request = 1'b0;
    logic                is_write = 1'b0;
    logic [7:0]          target_address = 8'h00;
    logic [31:0]         write_value = 32'h0;
    logic [IN_PINS-1:0]  inputs = '0;
    logic [IO_PINS-1:0]  io_inputs = '0;
    logic                spi_done = 1'b0;
    logic [7:0]          spi_rx_byte = 8'h00;

    logic [31:0]         fetched_value;
    logic                request_done;
    logic [OUT_PINS-1:0] outputs;
    logic [IO_PINS-1:0]  io_direction;
    logic [IO_PINS-1:0]  io_outputs;
    logic                spi_start;
    logic [7:0]          spi_tx_byte;
    logic [NUM_CS-1:0]   spi_cs_n;
    logic                irq;

    // Second instance with a short watchdog; its engine never answers.
    logic                to_req = 1'b0;
    logic                to_spi_done = 1'b0;
    logic [7:0]          to_spi_rx = 8'h00;
    logic [31:0]         to_fetched;
    logic                to_done;
    logic [OUT_PINS-1:0] to_outputs;
    logic [IO_PINS-1:0]  to_io_dir;
    logic [IO_PINS-1:0]  to_io_out;
    logic                to_spi_start;
    logic [7:0]          to_spi_tx;
    logic [NUM_CS-1:0]   to_cs_n;
    logic                to_irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    periph_bus #(.OUT_PINS(OUT_PINS), .IN_PINS(IN_PINS), .IO_PINS(IO_PINS),
                 .NUM_CS(NUM_CS), .SPI_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start_request(start_request), .is_write(is_write),
        .target_address(target_address), .write_value(write_value),
        .fetched_value(fetched_value), .request_done(request_done),
        .outputs(outputs), .inputs(inputs), .io_direction(io_direction),
        .io_outputs(io_outputs), .io_inputs(io_inputs), .spi_start(spi_start),
        .spi_tx_byte(spi_tx_byte), .spi_done(spi_done), .spi_rx_byte(spi_rx_byte),
        .spi_cs_n(spi_cs_n), .irq(irq)
    );

    periph_bus #(.OUT_PINS(OUT_PINS), .IN_PINS(IN_PINS), .IO_PINS(IO_PINS),
                 .NUM_CS(NUM_CS), .SPI_TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .start_request(to_req), .is_write(is_write),
        .target_address(target_address), .write_value(write_value),
        .fetched_value(to_fetched), .request_done(to_done),
        .outputs(to_outputs), .inputs(inputs), .io_direction(to_io_dir),
        .io_outputs(to_io_out), .io_inputs(io_inputs), .spi_start(to_spi_start),
        .spi_tx_byte(to_spi_tx), .spi_done(to_spi_done), .spi_rx_byte(to_spi_rx),
        .spi_cs_n(to_cs_n), .irq(to_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus transaction on either instance; reads pop their expectation
    // from the scoreboard when request_done appears.
    task automatic access(input bit which, input logic wr, input logic [7:0] a,
                          input logic [31:0] d, input int exp_lat, input string tag);
        int   n;
        logic done;
        exp_t e;
        @(negedge clk);
        is_write       = wr;
        target_address = a;
        write_value    = d;
        if (which) to_req = 1'b1; else start_request = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            done = which ? to_done : request_done;
        end while (!done && n < 200);
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (!wr && sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, which ? to_fetched : fetched_value, e.exp);
        end
        @(negedge clk);
        start_request = 1'b0;
        to_req        = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_release"}, 32'(which ? to_done : request_done), 32'd0);
        $display("txn %s %s addr=0x%02h data=0x%08h cycles=%0d", tag,
                 wr ? "WR" : "RD", a, wr ? d : (which ? to_fetched : fetched_value), n);
    endtask

    task automatic rd(input bit which, input logic [7:0] a, input logic [31:0] exp,
                      input string tag);
        sb.push_back('{tag, exp});
        access(which, 1'b0, a, 32'h0, 1, tag);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input string tag);
        access(1'b0, 1'b1, a, d, 1, tag);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetched", fetched_value, 32'h0);
        chk("rst_done", 32'(request_done), 32'd0);
        chk("rst_outputs", 32'(outputs), 32'h0);
        chk("rst_dir", 32'(io_direction), 32'h0);
        chk("rst_io_out", 32'(io_outputs), 32'h0);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_cs_n", 32'(spi_cs_n), 32'hF);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_to_cs_n", 32'(to_cs_n), 32'hF);
        @(negedge clk);
        rst = 1'b0;

        // GPIO direction masking and readback
        wr(8'h02, 32'h0F, "wr_dir");
        wr(8'h04, 32'h7F, "wr_pin_out");
        chk("io_outputs", 32'(io_outputs), 32'h0F);
        rd(1'b0, 8'h04, 32'h7F, "rd_pin_out");
        rd(1'b0, 8'h02, 32'h0F, "rd_dir");

        // OUT truncated to pin width, IN synchronised
        wr(8'h00, 32'hFF, "wr_out");
        chk("outputs", 32'(outputs), 32'hF);
        rd(1'b0, 8'h00, 32'hF, "rd_out");
        @(negedge clk);
        inputs = 5'h13;
        repeat (3) @(posedge clk);
        rd(1'b0, 8'h01, 32'h13, "rd_in");

        // PIN_IN masks output pins; rising edges on input pins set pending
        @(negedge clk);
        io_inputs = 7'h35;
        repeat (3) @(posedge clk);
        rd(1'b0, 8'h03, 32'h30, "rd_pin_in");
        rd(1'b0, 8'h1A, 32'h30, "rd_pend_noen");
        chk("irq_noen", 32'(irq), 32'd0);
        @(negedge clk);
        io_inputs = 7'h00;
        repeat (4) @(posedge clk);
        wr(8'h1A, 32'h7F, "w1c_all");
        rd(1'b0, 8'h1A, 32'h00, "rd_pend_clr");

        // Unmapped accesses
        wr(8'h30, 32'hFFFF_FFFF, "wr_unmapped");
        rd(1'b0, 8'h30, 32'h0, "rd_unmapped");
        rd(1'b0, 8'h00, 32'hF, "rd_out_keep");

        // Edge interrupt on pin 0
        wr(8'h02, 32'h00, "wr_dir0");
        wr(8'h18, 32'h01, "wr_irq_en");
        wr(8'h19, 32'h00, "wr_irq_edge");
        @(negedge clk);
        io_inputs = 7'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_lag", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_set", 32'(irq), 32'd1);
        rd(1'b0, 8'h1A, 32'h01, "rd_pend_set");
        wr(8'h1A, 32'h01, "w1c_pin0");
        chk("irq_clr", 32'(irq), 32'd0);
        rd(1'b0, 8'h1A, 32'h00, "rd_pend_w1c");

        // Re-arm pending, then clear in the same cycle a new edge arrives
        @(negedge clk); io_inputs = 7'h00;
        repeat (4) @(posedge clk);
        @(negedge clk); io_inputs = 7'h01;
        repeat (4) @(posedge clk);
        @(negedge clk); io_inputs = 7'h00;
        repeat (4) @(posedge clk);
        @(negedge clk); io_inputs = 7'h01;
        @(posedge clk);
        @(posedge clk);
        wr(8'h1A, 32'h01, "w1c_coincident");
        rd(1'b0, 8'h1A, 32'h01, "rd_pend_setwins");
        chk("irq_setwins", 32'(irq), 32'd1);

        // Falling edge on pin 2
        wr(8'h19, 32'h04, "wr_edge_fall");
        @(negedge clk); io_inputs = 7'h05;
        repeat (4) @(posedge clk);
        rd(1'b0, 8'h1A, 32'h01, "rd_pend_rise2");
        @(negedge clk); io_inputs = 7'h01;
        repeat (4) @(posedge clk);
        rd(1'b0, 8'h1A, 32'h05, "rd_pend_fall2");

        // SPI transfer on CS1, engine answers after 20 cycles
        wr(8'h08, 32'hA5, "wr_spi_tx");
        chk("spi_tx_byte", 32'(spi_tx_byte), 32'hA5);
        @(negedge clk);
        is_write = 1'b1; target_address = 8'h05; write_value = 32'h05;
        start_request = 1'b1;
        @(posedge clk); #1;
        chk("spi_start_on", 32'(spi_start), 32'd1);
        chk("spi_cs_pend", 32'(spi_cs_n), 32'b1101);
        chk("spi_not_done", 32'(request_done), 32'd0);
        repeat (19) @(posedge clk);
        #1;
        chk("spi_hold", 32'(spi_start), 32'd1);
        @(negedge clk);
        spi_done = 1'b1; spi_rx_byte = 8'h3C;
        @(posedge clk); #1;
        chk("spi_req_done", 32'(request_done), 32'd1);
        chk("spi_start_off", 32'(spi_start), 32'd0);
        chk("spi_cs_rel", 32'(spi_cs_n), 32'hF);
        @(negedge clk);
        spi_done = 1'b0; start_request = 1'b0;
        @(posedge clk); #1;
        chk("spi_release", 32'(request_done), 32'd0);
        $display("txn spi_xfer WR addr=0x05 data=0x00000005 rx=0x3C");
        rd(1'b0, 8'h0C, 32'h3C, "rd_spi_rx");
        rd(1'b0, 8'h05, 32'h2, "rd_spi_ctrl");

        // Watchdog expiry on the short-timeout instance
        @(negedge clk);
        is_write = 1'b1; target_address = 8'h05; write_value = 32'h05;
        to_req = 1'b1;
        @(posedge clk); #1;
        n = 1;
        chk("to_cs_pend", 32'(to_cs_n), 32'b1101);
        while (!to_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_latency", 32'(n), 32'd17);
        chk("to_spi_start", 32'(to_spi_start), 32'd0);
        chk("to_cs_rel", 32'(to_cs_n), 32'hF);
        @(negedge clk);
        to_req = 1'b0;
        @(posedge clk); #1;
        chk("to_release", 32'(to_done), 32'd0);
        $display("txn to_spi WR addr=0x05 data=0x00000005 cycles=%0d", n);
        rd(1'b1, 8'h05, 32'h4, "to_rd_ctrl");
        rd(1'b1, 8'h0C, 32'h0, "to_rd_rx");

        // Asynchronous reset in the middle of a transfer
        @(negedge clk);
        is_write = 1'b1; target_address = 8'h05; write_value = 32'h03;
        start_request = 1'b1;
        @(posedge clk); #1;
        chk("ar_cs_pend", 32'(spi_cs_n), 32'b1110);
        chk("ar_spi_start", 32'(spi_start), 32'd1);
        #2;
        rst = 1'b1;
        start_request = 1'b0;
        #1;
        chk("ar_spi_off", 32'(spi_start), 32'd0);
        chk("ar_cs_n", 32'(spi_cs_n), 32'hF);
        chk("ar_done", 32'(request_done), 32'd0);
        chk("ar_outputs", 32'(outputs), 32'h0);
        chk("ar_irq", 32'(irq), 32'd0);
        chk("ar_fetched", fetched_value, 32'h0);
        chk("ar_tx", 32'(spi_tx_byte), 32'h0);
        $display("txn async_reset mid-transfer");
        @(negedge clk);
        rst = 1'b0;
        rd(1'b0, 8'h05, 32'h0, "rd_ctrl_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
